// File: rtl/tstate_sequencer.sv
// T-state sequencer for the SAP-II ring counter: advance, stall, early clear, halt/restart, recovery.
// Optional single-step gating is enabled by defining SINGLE_STEP_EN.
//
// state | meaning
// IDLE  | after reset; ring held at T1, waiting for run
// RUN   | sequencing T-states of the current instruction
// HALT  | HLT executed; ring held at T1, needs run low then high to restart
module tstate_sequencer #(
    parameter int NT      = 18,
    parameter int FETCH_T = 3,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             nCLR,
    input  logic [NT-1:0]    state,
    input  logic [4:0]       len,
    input  logic             hlt,
    input  logic             rdy,
    input  logic             run,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             t_en,
    output logic             ring_nclr,
    output logic             instr_done,
    output logic             halted,
    output logic             len_err,
    output logic [4:0]       cur_len,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [4:0] LEN_MIN = 5'(FETCH_T + 1);
    localparam logic [4:0] LEN_MAX = 5'(NT);

    logic [1:0] fsm;
    logic       sampled;
    logic       armed;
    logic       one_hot;
    logic       len_lo;
    logic       len_hi;
    logic [4:0] len_clamp;
    logic       sample_now;
    logic [4:0] eff_len;
    logic       len_hit;
    logic       is_last;
    logic       step_ok;
    logic       adv;

`ifdef SINGLE_STEP_EN
    logic step_q;
    logic step_pulse;

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            step_q     <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_q     <= step;
            step_pulse <= step & ~step_q;
        end
    end

    assign step_ok = step_pulse;
`else
    assign step_ok = 1'b1;
`endif

    assign adv = rdy & step_ok;

    always_comb begin
        one_hot    = (state != '0) && ((state & (state - NT'(1))) == '0);
        len_lo     = (len < LEN_MIN);
        len_hi     = (len > LEN_MAX);
        len_clamp  = len_lo ? LEN_MIN : (len_hi ? LEN_MAX : len);
        sample_now = (fsm == S_RUN) && one_hot && state[FETCH_T] && !sampled;
        // The sampling cycle already uses the fresh length so a minimum-length instruction ends on time.
        eff_len    = sample_now ? len_clamp : cur_len;
        len_hit    = 1'b0;
        for (int i = 0; i < NT; i++) begin
            if (state[i] && (eff_len == 5'(i + 1))) len_hit = 1'b1;
        end
        is_last    = ((sampled || sample_now) && len_hit) || state[NT-1];
    end

    always_comb begin
        t_en       = 1'b0;
        ring_nclr  = 1'b0;
        instr_done = 1'b0;
        if (nCLR) begin
            if (fsm != S_RUN) begin
                t_en = 1'b1;
            end else if (!one_hot) begin
                t_en = 1'b1;
            end else if (is_last && adv) begin
                t_en       = 1'b1;
                instr_done = 1'b1;
            end else begin
                t_en      = adv;
                ring_nclr = 1'b1;
            end
        end
    end

    assign halted = !nCLR || (fsm != S_RUN);

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            fsm       <= S_IDLE;
            sampled   <= 1'b0;
            armed     <= 1'b0;
            len_err   <= 1'b0;
            cur_len   <= LEN_MAX;
            instr_cnt <= '0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    sampled <= 1'b0;
                    if (run) fsm <= S_RUN;
                end
                S_RUN: begin
                    if (!one_hot) begin
                        len_err <= 1'b1;
                        sampled <= 1'b0;
                    end else begin
                        if (sample_now) begin
                            cur_len <= len_clamp;
                            sampled <= 1'b1;
                            if (len_lo || len_hi) len_err <= 1'b1;
                        end
                        if (instr_done) begin
                            instr_cnt <= instr_cnt + CNT_W'(1);
                            sampled   <= 1'b0;
                            if (hlt) begin
                                fsm   <= S_HALT;
                                armed <= 1'b0;
                            end
                        end
                    end
                end
                S_HALT: begin
                    sampled <= 1'b0;
                    // A run level held across the HLT must drop before it can restart.
                    if (!run)       armed <= 1'b1;
                    else if (armed) fsm   <= S_RUN;
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tstate_sequencer.sv
// Directed bench for tstate_sequencer with a behavioural ring counter and a state override for fault injection.
module tb_tstate_sequencer;

    logic        CLK = 1'b0;
    logic        nCLR;
    logic [17:0] state;
    logic [4:0]  len;
    logic        hlt;
    logic        rdy;
    logic        run;
    logic        t_en;
    logic        ring_nclr;
    logic        instr_done;
    logic        halted;
    logic        len_err;
    logic [4:0]  cur_len;
    logic [15:0] instr_cnt;
`ifdef SINGLE_STEP_EN
    logic        step = 1'b0;
`endif

    logic [17:0] ring = 18'h1;
    logic        ovr;
    logic [17:0] ovr_val;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (t_en) ring <= ring_nclr ? {ring[16:0], ring[17]} : 18'h1;
    end

    assign state = ovr ? ovr_val : ring;

    tstate_sequencer dut (
        .CLK        (CLK),
        .nCLR       (nCLR),
        .state      (state),
        .len        (len),
        .hlt        (hlt),
        .rdy        (rdy),
        .run        (run),
`ifdef SINGLE_STEP_EN
        .step       (step),
`endif
        .t_en       (t_en),
        .ring_nclr  (ring_nclr),
        .instr_done (instr_done),
        .halted     (halted),
        .len_err    (len_err),
        .cur_len    (cur_len),
        .instr_cnt  (instr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nCLR = 1'b0; run = 1'b0; rdy = 1'b1; len = 5'd4; hlt = 1'b0;
        ovr = 1'b0; ovr_val = 18'h0;
        tick();
        chk("rst_halted", halted, 1);
        chk("rst_t_en", t_en, 0);
        chk("rst_nclr", ring_nclr, 0);
        chk("rst_done", instr_done, 0);
        chk("rst_cur_len", cur_len, 18);
        chk("rst_cnt", instr_cnt, 0);
        chk("rst_len_err", len_err, 0);

        nCLR = 1'b1; #1;
        chk("idle_t_en", t_en, 1);
        chk("idle_nclr", ring_nclr, 0);
        chk("idle_halted", halted, 1);
        tick();
        chk("idle_ring", ring, 18'h1);

        // len=4 instruction
        run = 1'b1; len = 5'd4;
        tick();
        chk("l4_halted", halted, 0);
        chk("l4_t1", ring, 18'h1);
        chk("l4_t1_t_en", t_en, 1);
        chk("l4_t1_nclr", ring_nclr, 1);
        tick(); tick();
        chk("l4_t3", ring, 18'h4);
        chk("l4_t3_done", instr_done, 0);
        tick();
        chk("l4_t4", ring, 18'h8);
        chk("l4_t4_done", instr_done, 1);
        chk("l4_t4_nclr", ring_nclr, 0);
        tick();
        chk("l4_wrap", ring, 18'h1);
        chk("l4_cnt", instr_cnt, 1);
        chk("l4_cur_len", cur_len, 4);
        chk("l4_done_off", instr_done, 0);

        // len=7 with 3-cycle stall in T6
        len = 5'd7;
        repeat (5) tick();
        chk("l7_t6", ring, 18'h20);
        rdy = 1'b0; #1;
        chk("l7_stall_t_en", t_en, 0);
        tick();
        chk("l7_t6_b", ring, 18'h20);
        tick();
        chk("l7_t6_c", ring, 18'h20);
        chk("l7_stall_done", instr_done, 0);
        rdy = 1'b1;
        tick();
        chk("l7_t7", ring, 18'h40);
        chk("l7_t7_done", instr_done, 1);
        chk("l7_cur_len", cur_len, 7);
        tick();
        chk("l7_wrap", ring, 18'h1);
        chk("l7_cnt", instr_cnt, 2);

        // all-zero state in RUN
        len = 5'd5;
        tick();
        ovr = 1'b1; ovr_val = 18'h0; #1;
        chk("z_nclr", ring_nclr, 0);
        chk("z_t_en", t_en, 1);
        chk("z_done", instr_done, 0);
        chk("z_err_pre", len_err, 0);
        tick();
        chk("z_err", len_err, 1);
        ovr = 1'b0; #1;
        chk("z_ring", ring, 18'h1);
        chk("z_cnt", instr_cnt, 2);
        chk("z_nclr_after", ring_nclr, 1);

        // reset mid-instruction at T5
        len = 5'd6;
        repeat (4) tick();
        chk("mr_t5", ring, 18'h10);
        nCLR = 1'b0; #1;
        chk("mr_halted", halted, 1);
        chk("mr_t_en", t_en, 0);
        chk("mr_nclr", ring_nclr, 0);
        chk("mr_cnt", instr_cnt, 0);
        chk("mr_len_err", len_err, 0);
        chk("mr_cur_len", cur_len, 18);
        tick();
        nCLR = 1'b1; #1;
        chk("mr_ring_held", ring, 18'h10);
        chk("mr_idle_t_en", t_en, 1);
        chk("mr_idle_nclr", ring_nclr, 0);
        tick();
        chk("mr_ring_t1", ring, 18'h1);
        chk("mr_run", halted, 0);

        // low clamp
        len = 5'd2;
        repeat (3) tick();
        chk("lo_t4", ring, 18'h8);
        chk("lo_done", instr_done, 1);
        tick();
        chk("lo_cur_len", cur_len, 4);
        chk("lo_len_err", len_err, 1);
        chk("lo_cnt", instr_cnt, 1);

        // high clamp
        len = 5'd25;
        repeat (17) tick();
        chk("hi_t18", ring, 18'h20000);
        chk("hi_done", instr_done, 1);
        tick();
        chk("hi_cur_len", cur_len, 18);
        chk("hi_cnt", instr_cnt, 2);
        chk("hi_ring", ring, 18'h1);
        chk("hi_len_err", len_err, 1);

        // HLT with run held, then restart
        len = 5'd5; hlt = 1'b1;
        repeat (4) tick();
        chk("h_t5", ring, 18'h10);
        chk("h_done", instr_done, 1);
        tick();
        chk("h_halted", halted, 1);
        chk("h_cnt", instr_cnt, 3);
        chk("h_ring", ring, 18'h1);
        repeat (3) tick();
        chk("h_hold", halted, 1);
        chk("h_hold_ring", ring, 18'h1);
        hlt = 1'b0; run = 1'b0;
        tick();
        chk("h_run_low", halted, 1);
        run = 1'b1;
        tick();
        chk("h_restart", halted, 0);
        chk("h_restart_t1", ring, 18'h1);
        chk("h_restart_t_en", t_en, 1);

        // two-hot state in RUN
        tick();
        ovr = 1'b1; ovr_val = 18'h3; #1;
        chk("d_nclr", ring_nclr, 0);
        chk("d_done", instr_done, 0);
        tick();
        ovr = 1'b0; #1;
        chk("d_ring", ring, 18'h1);
        chk("d_cnt", instr_cnt, 3);
        chk("d_len_err", len_err, 1);

        // stall in T4: length sampled only once
        len = 5'd5;
        repeat (3) tick();
        chk("s_t4", ring, 18'h8);
        rdy = 1'b0; #1;
        chk("s_t_en", t_en, 0);
        chk("s_done", instr_done, 0);
        tick();
        chk("s_t4_held", ring, 18'h8);
        len = 5'd9; rdy = 1'b1; #1;
        chk("s_t4_nclr", ring_nclr, 1);
        tick();
        chk("s_t5", ring, 18'h10);
        chk("s_t5_done", instr_done, 1);
        tick();
        chk("s_ring", ring, 18'h1);
        chk("s_cnt", instr_cnt, 4);
        chk("s_cur_len", cur_len, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
